// File: rtl/stream_pkg.sv
// Shared definitions for the stream FIFO slice: default data width,
// the word type and a constant-foldable ceil(log2) helper.
package stream_pkg;

    localparam int STREAM_DATA_WIDTH = 32;

    typedef logic [STREAM_DATA_WIDTH-1:0] stream_word_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_fifo_ram.sv
// Storage array for stream_fifo: synchronous write, asynchronous read.
// Kept separate so it can later be swapped for a LUTRAM/BRAM primitive.
module stream_fifo_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Contents are not reset; pointers alone decide what is valid.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through FIFO with negated-flag stream handshakes.
// Define STREAM_FIFO_COUNT_EN to add the registered occupancy port count.
module stream_fifo
    import stream_pkg::*;
#(
    parameter int  DATA_WIDTH = STREAM_DATA_WIDTH,
    parameter int  DEPTH      = 16,
    localparam int ADDR_WIDTH = clog2(DEPTH)
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  write,
    output logic                  full_n,
    output logic [DATA_WIDTH-1:0] dout,
    input  logic                  read,
    output logic                  empty_n
`ifdef STREAM_FIFO_COUNT_EN
    ,
    output logic [ADDR_WIDTH:0]   count
`endif
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic                empty_n_q, empty_n_d;
    logic                full_n_q, full_n_d;
    logic                wr_en, rd_en;

    assign wr_en = write && full_n_q;
    assign rd_en = read && empty_n_q;

    // Next pointers and flags; flags depend only on next-state pointers.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        empty_n_d = (wr_ptr_d != rd_ptr_d);
        full_n_d  = !((wr_ptr_d[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0])
                   && (wr_ptr_d[ADDR_WIDTH] != rd_ptr_d[ADDR_WIDTH]));
    end

    // Pointer and flag registers, cleared asynchronously.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            empty_n_q <= 1'b0;
            full_n_q  <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            empty_n_q <= empty_n_d;
            full_n_q  <= full_n_d;
        end
    end

    assign empty_n = empty_n_q;
    assign full_n  = full_n_q;

    stream_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk_i   (ap_clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata_i (din),
        .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata_o (dout)
    );

`ifdef STREAM_FIFO_COUNT_EN
    logic [ADDR_WIDTH:0] count_q, count_d;

    // Occupancy moves only when exactly one side is accepted.
    always_comb begin
        count_d = count_q;
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + PTR_ONE;
            2'b01:   count_d = count_q - PTR_ONE;
            default: count_d = count_q;
        endcase
    end

    // Occupancy register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo (DEPTH=4): queue model, directed
// boundary cases with literal expectations, then randomized traffic.
module tb_stream_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          ap_clk;
    logic          ap_rst_n;
    logic [DW-1:0] din;
    logic          write;
    logic          full_n;
    logic [DW-1:0] dout;
    logic          read;
    logic          empty_n;
`ifdef STREAM_FIFO_COUNT_EN
    logic [2:0]    count;
`endif

    stream_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .din      (din),
        .write    (write),
        .full_n   (full_n),
        .dout     (dout),
        .read     (read),
        .empty_n  (empty_n)
`ifdef STREAM_FIFO_COUNT_EN
        ,
        .count    (count)
`endif
    );

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mq [$];

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp,
                     $time);
        end
    endtask

    // Reference model: a plain queue updated by the acceptance rules.
    always @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            mq.delete();
        end else begin
            bit wa, ra;
            wa = write && (mq.size() < DEPTH);
            ra = read && (mq.size() > 0);
            if (ra) void'(mq.pop_front());
            if (wa) mq.push_back(din);
        end
    end

    // Compare DUT outputs with the model every cycle, away from the edge.
    always @(negedge ap_clk) begin
        check("m_empty_n", 64'(empty_n), 64'(mq.size() != 0));
        check("m_full_n", 64'(full_n), 64'(mq.size() != DEPTH));
        if (mq.size() != 0) begin
            check("m_dout", 64'(dout), 64'(mq[0]));
        end
`ifdef STREAM_FIFO_COUNT_EN
        check("m_count", 64'(count), 64'(mq.size()));
`endif
    end

    task automatic step(input logic w, input logic [DW-1:0] d,
                        input logic r);
        write = w;
        din   = d;
        read  = r;
        @(posedge ap_clk);
        #1;
    endtask

    initial begin
        ap_rst_n = 1'b0;
        write    = 1'b1;
        din      = 32'hDEAD;
        read     = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1;
        check("rst_empty_n", 64'(empty_n), 64'd0);
        check("rst_full_n", 64'(full_n), 64'd1);
`ifdef STREAM_FIFO_COUNT_EN
        check("rst_count", 64'(count), 64'd0);
`endif
        write = 1'b0;
        #1 ap_rst_n = 1'b1;
        step(0, 0, 0);
        check("post_rst_empty", 64'(empty_n), 64'd0);

        for (int i = 1; i <= 4; i++) step(1, DW'(i), 0);
        check("fill_full_n", 64'(full_n), 64'd0);
        check("fill_head", 64'(dout), 64'd1);
`ifdef STREAM_FIFO_COUNT_EN
        check("fill_count", 64'(count), 64'd4);
`endif
        step(1, 32'h5, 0);
        check("ovf_full_n", 64'(full_n), 64'd0);
        check("ovf_head", 64'(dout), 64'd1);

        for (int i = 1; i <= 4; i++) begin
            check("drain_dout", 64'(dout), 64'(i));
            step(0, 0, 1);
        end
        check("drain_empty_n", 64'(empty_n), 64'd0);
        step(0, 0, 1);
        step(1, 32'h77, 0);
        check("udf_dout", 64'(dout), 64'h77);
        step(0, 0, 1);

        step(1, 32'h10, 0);
        step(1, 32'h11, 0);
        for (int i = 0; i < 10; i++) begin
            logic [DW-1:0] e;
            e = (i < 2) ? DW'(32'h10 + i) : DW'(32'hA0 + i - 2);
            check("sim_dout", 64'(dout), 64'(e));
            step(1, DW'(32'hA0 + i), 1);
        end
        check("sim_dout_end", 64'(dout), 64'hA8);
`ifdef STREAM_FIFO_COUNT_EN
        check("sim_count", 64'(count), 64'd2);
`endif
        step(0, 0, 1);
        step(0, 0, 1);
        check("sim_empty", 64'(empty_n), 64'd0);

        step(1, 32'h55, 1);
        check("er_empty_n", 64'(empty_n), 64'd1);
        check("er_dout", 64'(dout), 64'h55);
        step(0, 0, 1);

        for (int i = 1; i <= 4; i++) step(1, DW'(32'h60 + i), 0);
        step(1, 32'h99, 1);
        check("fr_full_n", 64'(full_n), 64'd1);
        check("fr_dout", 64'(dout), 64'h62);

        #2 ap_rst_n = 1'b0;
        #1;
        check("ar_empty_n", 64'(empty_n), 64'd0);
        check("ar_full_n", 64'(full_n), 64'd1);
        @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        step(1, 32'h33, 0);
        check("ar_push_dout", 64'(dout), 64'h33);
        check("ar_push_empty_n", 64'(empty_n), 64'd1);
        step(0, 0, 1);
        check("ar_pop_empty", 64'(empty_n), 64'd0);

        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 1)), DW'($urandom),
                 1'($urandom_range(0, 1)));
        end
        step(0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
